// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the chunked serial adder:
//   state_t       - control FSM encoding (IDLE, RUN, DONE), 2 bits
//   calc_nchunk   - number of clock cycles (chunks) per operation
//   params_legal  - WIDTH/CHUNK legality check used at elaboration
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // CHUNK must be at least one bit, no wider than the operand, and divide it.
    function automatic bit params_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  [CHUNK-1:0]  addend slices
//   cin                carry into bit 0
//   s     [CHUNK-1:0]  sum slice
//   cout               carry out of bit CHUNK-1
// -----------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
// Multi-cycle WIDTH-bit adder computing ip1 + ip2 + c_in, CHUNK bits per clock,
// with the carry registered between chunks.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. in_ready is high only in IDLE; out_valid is high only in DONE, and sum /
// c_out stay frozen there until out_ready is seen. Both flags decode registered
// state, so neither depends combinationally on the other side.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   in_valid/in_ready  operand handshake
//   ip1, ip2, c_in     operands and carry-in, sampled on acceptance
//   out_valid/out_ready result handshake
//   sum, c_out         registered result and carry-out of the MSB
//   state_dbg          current FSM state (serial_adder_pkg::state_t encoding)
// Optional (macro SERIAL_ADDER_SUB_EN):
//   sub                1 = compute ip1 - ip2 (B captured as ~ip2, carry-in 1)
//   ovf                registered signed overflow of the last operation
// -----------------------------------------------------------------------------
module chunked_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
        $error("chunked_serial_adder: CHUNK must be 1..WIDTH and divide WIDTH");
    end

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  b_load;
    logic              cin_load;
    logic [CHUNK-1:0]  ch_s;
    logic              ch_cout;
    logic [WIDTH-1:0]  sum_nx;
    logic              last_chunk;

`ifdef SERIAL_ADDER_SUB_EN
    // Operand sign bits are consumed by the shifters, so keep a copy for ovf.
    logic a_msb;
    logic b_msb;

    assign b_load   = sub ? ~ip2 : ip2;
    assign cin_load = sub ? 1'b1 : c_in;
`else
    assign b_load   = ip2;
    assign cin_load = c_in;
`endif

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry),
        .s    (ch_s),
        .cout (ch_cout)
    );

    // New chunk enters at the MSB end; after NCHUNK shifts the first chunk has
    // reached bit 0. Written with shifts so CHUNK == WIDTH needs no special case.
    assign sum_nx     = (sum >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
    assign last_chunk = (idx == LAST_IDX);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = RUN;
            RUN:     if (last_chunk) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= ip1;
                        b_sh  <= b_load;
                        carry <= cin_load;
                        idx   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        a_msb <= ip1[WIDTH-1];
                        b_msb <= b_load[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    sum   <= sum_nx;
                    carry <= ch_cout;
                    idx   <= idx + IDXW'(1);
                    if (last_chunk) begin
                        c_out <= ch_cout;
`ifdef SERIAL_ADDER_SUB_EN
                        // Top bit of the final chunk becomes the sum MSB.
                        ovf <= (a_msb == b_msb) && (ch_s[CHUNK-1] != a_msb);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_serial_adder
// Self-checking bench for chunked_serial_adder. The main instance (8,2) is
// driven through send(); each issued operation pushes its expected
// {ovf, c_out, sum} into exp_q and a monitor pops/compares on every output
// handshake. Three extra instances (8,1), (8,8), (16,4) check latency and the
// full carry chain. Honours SERIAL_ADDER_SUB_EN for the subtract cases.
// -----------------------------------------------------------------------------
module tb_chunked_serial_adder;
    import serial_adder_pkg::*;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  ip1;
    logic [7:0]  ip2;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  sum;
    logic        c_out;
    logic [1:0]  state_dbg;
    logic        ovf_w;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub;
    logic        ovf;
    logic        ovf_a;
    logic        ovf_b;
    logic        ovf_c;
    assign ovf_w = ovf;
`else
    assign ovf_w = 1'b0;
`endif

    // ---------------- sweep instance signals ----------------
    logic        sw_valid;
    logic [7:0]  sw_a8;
    logic [7:0]  sw_b8;
    logic [15:0] sw_a16;
    logic [15:0] sw_b16;
    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [7:0]  s_a, s_b;
    logic [15:0] s_c;
    logic        co_a, co_b, co_c;
    logic [1:0]  st_a, st_b, st_c;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ip1(ip1), .ip2(ip2), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub), .ovf(ovf),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out),
        .state_dbg(state_dbg)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_a),
        .ip1(sw_a8), .ip2(sw_b8), .c_in(1'b0),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0), .ovf(ovf_a),
`endif
        .out_valid(ov_a), .out_ready(1'b1), .sum(s_a), .c_out(co_a),
        .state_dbg(st_a)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_b),
        .ip1(sw_a8), .ip2(sw_b8), .c_in(1'b0),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0), .ovf(ovf_b),
`endif
        .out_valid(ov_b), .out_ready(1'b1), .sum(s_b), .c_out(co_b),
        .state_dbg(st_b)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy_c),
        .ip1(sw_a16), .ip2(sw_b16), .c_in(1'b0),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0), .ovf(ovf_c),
`endif
        .out_valid(ov_c), .out_ready(1'b1), .sum(s_c), .c_out(co_c),
        .state_dbg(st_c)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];
    int n_vec  = 0;
    int n_err  = 0;
    int n_sent = 0;
    int n_out  = 0;
    bit bp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit addition, ovf only exists in the sub build.
    function automatic logic [9:0] add_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic ci);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        return {OVF_EN & (a[7] == b[7]) & (s[7] != a[7]), s};
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [9:0] exp);
        int wait_cnt;
        wait_cnt = 0;
        in_valid = 1'b1;
        ip1 = a;
        ip2 = b;
        c_in = ci;
        @(negedge clk);
        while (!in_ready && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (in_ready) begin
            exp_q.push_back(exp);
            n_sent++;
        end else begin
            check("send_in_ready_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 500) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got 0x%0h, none expected",
                             {ovf_w, c_out, sum});
                end else begin
                    check("result", 32'({ovf_w, c_out, sum}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Random backpressure, only while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- sweep ----------------
    task automatic run_sweep();
        int lat_a, lat_b, lat_c;
        logic [8:0]  r_a, r_b;
        logic [16:0] r_c;
        lat_a = -1; lat_b = -1; lat_c = -1;
        r_a = '0; r_b = '0; r_c = '0;
        sw_a8 = 8'hFF; sw_b8 = 8'h01; sw_a16 = 16'hFFFF; sw_b16 = 16'h0001;
        sw_valid = 1'b1;
        @(negedge clk);
        check("sweep_in_ready", 32'({rdy_a, rdy_b, rdy_c}), 32'b111);
        check("sweep_state_idle", 32'({st_a, st_b, st_c}), 32'({IDLE, IDLE, IDLE}));
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(posedge clk);
            #1;
            if (ov_a && lat_a < 0) begin lat_a = cyc; r_a = {co_a, s_a}; end
            if (ov_b && lat_b < 0) begin lat_b = cyc; r_b = {co_b, s_b}; end
            if (ov_c && lat_c < 0) begin lat_c = cyc; r_c = {co_c, s_c}; end
        end
        check("lat_w8c1", 32'(lat_a), 32'd8);
        check("lat_w8c8", 32'(lat_b), 32'd1);
        check("lat_w16c4", 32'(lat_c), 32'd4);
        check("res_w8c1", 32'(r_a), 32'h100);
        check("res_w8c8", 32'(r_b), 32'h100);
        check("res_w16c4", 32'(r_c), 32'h10000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0;
        ip1 = '0; ip2 = '0; c_in = 1'b0;
        out_ready = 1'b1;
        sw_valid = 1'b0;
        sw_a8 = '0; sw_b8 = '0; sw_a16 = '0; sw_b16 = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;

        // 0xFF + 0x01: full carry chain, 4-cycle latency.
        send(8'hFF, 8'h01, 1'b0, {1'b0, 9'h100});
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t1_latency", 32'(lat), 32'd4);
        @(posedge clk);
        #1;

        // 0x5A + 0x33 + 1 under 10 cycles of backpressure.
        out_ready = 1'b0;
        send(8'h5A, 8'h33, 1'b1, {OVF_EN, 9'h08E});
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t2_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'h8E);
            check("hold_c_out", 32'(c_out), 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'(i % 2);
            ip1 = 8'($urandom_range(0, 255));
            ip2 = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back random operands with random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] a, b;
            logic ci;
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            send(a, b, ci, add_model(a, b, ci));
        end
        bp_en = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("no_loss_no_dup", 32'(n_out), 32'(n_sent));

        // Abort mid-RUN: after two RUN edges, reset for one edge.
        send(8'h77, 8'h11, 1'b0, {1'b0, 9'h088});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        n_sent--;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        send(8'h10, 8'h20, 1'b0, {1'b0, 9'h030});
        wait_drain();

        run_sweep();

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        send(8'h80, 8'h01, 1'b0, {1'b1, 1'b1, 8'h7F});
        send(8'h03, 8'h05, 1'b1, {1'b0, 1'b0, 8'hFE});
        sub = 1'b0;
        wait_drain();
`endif

        check("total_outputs", 32'(n_out), 32'(n_sent));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
